// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, status bit
// positions and the default window base.
package mmio_pkg;

  typedef enum logic [1:0] {
    OFF_PORT_OUT = 2'd0,
    OFF_PORT_IN  = 2'd1,
    OFF_STATUS   = 2'd2,
    OFF_CYCLES   = 2'd3
  } reg_sel_e;

  localparam int unsigned STATUS_CHANGED_BIT = 0;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/port_in_sync.sv
// Multi-flop synchroniser for an asynchronous input bus, plus a one-flop
// history register and a change pulse (sync_q != prev_q).
module port_in_sync #(
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] i_async,
  output logic [IN_WIDTH-1:0] o_sync,
  output logic                o_change
);

  logic [IN_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [IN_WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync   = r_sync[SYNC_STAGES-1];
  assign o_change = (r_sync[SYNC_STAGES-1] != r_prev);

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O target: PORT_OUT, synchronised PORT_IN, sticky change flag
// (W1C) and a loadable free-running cycle counter in a 16-byte window.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT,
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                InChanged
);

  logic [31:0]         r_port_out;
  logic [31:0]         r_cycles;
  logic                r_flag;
  logic [IN_WIDTH-1:0] w_sync;
  logic                w_change;
  reg_sel_e            w_sel;
  logic                w_wr_out;
  logic                w_wr_status;
  logic                w_wr_cycles;
  logic                w_unused_addr;

  assign Hit           = (Address[31:4] == IO_BASE[31:4]);
  assign w_sel         = reg_sel_e'(Address[3:2]);
  assign w_unused_addr = ^Address[1:0];

  port_in_sync #(
    .IN_WIDTH   (IN_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_port_in_sync (
    .clk     (clk),
    .rst_n   (reset),
    .i_async (PortIn),
    .o_sync  (w_sync),
    .o_change(w_change)
  );

  always_comb begin
    w_wr_out    = 1'b0;
    w_wr_status = 1'b0;
    w_wr_cycles = 1'b0;
    if (MemWrite && Hit) begin
      case (w_sel)
        OFF_PORT_OUT: w_wr_out    = 1'b1;
        OFF_STATUS:   w_wr_status = 1'b1;
        OFF_CYCLES:   w_wr_cycles = 1'b1;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= '0;
      r_cycles   <= '0;
      r_flag     <= 1'b0;
    end else begin
      if (w_wr_out) r_port_out <= WriteData;
      r_cycles <= w_wr_cycles ? WriteData : r_cycles + 32'd1;
      // a set event in the same cycle as a W1C wins
      if (w_change)
        r_flag <= 1'b1;
      else if (w_wr_status && WriteData[STATUS_CHANGED_BIT])
        r_flag <= 1'b0;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (w_sel)
        OFF_PORT_OUT: ReadData = r_port_out;
        OFF_PORT_IN:  ReadData = 32'(w_sync);
        OFF_STATUS:   ReadData[STATUS_CHANGED_BIT] = r_flag;
        OFF_CYCLES:   ReadData = r_cycles;
        default:      ReadData = '0;
      endcase
    end
  end

  assign PortOut   = r_port_out;
  assign InChanged = r_flag;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: load results go through a
// scoreboard queue, direct outputs are checked against bench constants.
module tb_mmio_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        InChanged;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] A_OUT = 32'hFFFF_0000;
  localparam logic [31:0] A_IN  = 32'hFFFF_0004;
  localparam logic [31:0] A_ST  = 32'hFFFF_0008;
  localparam logic [31:0] A_CYC = 32'hFFFF_000C;

  mmio_port_responder #(
    .IO_BASE    (32'hFFFF_0000),
    .IN_WIDTH   (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .InChanged(InChanged)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push the expectation when the load is driven; pop it once ReadData settles.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    Address = addr;
    MemRead = 1'b1;
    sb.push_back('{tag, exp});
    #1;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, ReadData, e.exp);
    end
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    step(1);
    MemWrite  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; Address = '0; WriteData = '0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    #12;
    check_val("rst_portout", PortOut, 32'h0);
    check_val("rst_inchanged", {31'b0, InChanged}, 32'h0);
    rd("rst_port_in", A_IN, 32'h0);
    rd("rst_cycles", A_CYC, 32'h0);
    #8 reset = 1'b1;
    step(1);

    // PORT_OUT write/read; low address bits ignored
    wr(A_OUT, 32'hDEAD_BEEF);
    check_val("portout_write", PortOut, 32'hDEAD_BEEF);
    rd("lw_port_out", A_OUT, 32'hDEAD_BEEF);
    check_val("hit_in_window", {31'b0, Hit}, 32'h1);
    rd("lw_port_out_misaligned", A_OUT | 32'h3, 32'hDEAD_BEEF);

    // Synchroniser latency and flag timing
    PortIn = 8'hA5;
    step(1);
    rd("port_in_1edge", A_IN, 32'h0);
    step(1);
    rd("port_in_2edge", A_IN, 32'h0000_00A5);
    check_val("flag_2edge", {31'b0, InChanged}, 32'h0);
    step(1);
    check_val("flag_3edge", {31'b0, InChanged}, 32'h1);
    rd("status_set", A_ST, 32'h1);

    wr(A_ST, 32'h0);
    check_val("w0_no_clear", {31'b0, InChanged}, 32'h1);
    wr(A_ST, 32'h1);
    check_val("w1c_clear", {31'b0, InChanged}, 32'h0);
    rd("status_cleared", A_ST, 32'h0);

    // Set and clear on the same edge: set wins
    PortIn = 8'h5A;
    step(2);
    wr(A_ST, 32'h1);
    check_val("set_wins", {31'b0, InChanged}, 32'h1);
    step(1);
    check_val("flag_sticky", {31'b0, InChanged}, 32'h1);
    wr(A_ST, 32'hFFFF_FFFF);
    check_val("w1c_clear2", {31'b0, InChanged}, 32'h0);

    wr(A_IN, 32'h77);
    rd("port_in_ro", A_IN, 32'h0000_005A);
    check_val("port_in_wr_no_side", PortOut, 32'hDEAD_BEEF);

    // Counter load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd("cyc_load", A_CYC, 32'hFFFF_FFFE);
    step(1);
    rd("cyc_inc", A_CYC, 32'hFFFF_FFFF);
    step(1);
    rd("cyc_wrap", A_CYC, 32'h0);

    // Out-of-window access
    Address = 32'h1001_0000; WriteData = 32'hCAFE_F00D;
    MemWrite = 1'b1;
    rd("oow_readdata", 32'h1001_0000, 32'h0);
    check_val("oow_hit", {31'b0, Hit}, 32'h0);
    MemWrite = 1'b1;
    step(1);
    MemWrite = 1'b0;
    check_val("oow_portout", PortOut, 32'hDEAD_BEEF);

    // Simultaneous read/write: read shows pre-edge value
    WriteData = 32'h0000_1234; MemWrite = 1'b1;
    rd("rw_pre_edge", A_OUT, 32'hDEAD_BEEF);
    MemWrite = 1'b1;
    step(1);
    MemWrite = 1'b0;
    check_val("rw_post_edge", PortOut, 32'h0000_1234);

    // Asynchronous reset mid-run
    PortIn = 8'h3C;
    step(3);
    check_val("pre_rst_flag", {31'b0, InChanged}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check_val("arst_portout", PortOut, 32'h0);
    check_val("arst_flag", {31'b0, InChanged}, 32'h0);
    rd("arst_cycles", A_CYC, 32'h0);
    rd("arst_port_in", A_IN, 32'h0);
    rd("arst_status", A_ST, 32'h0);
    step(2);
    rd("rst_held_cycles", A_CYC, 32'h0);
    reset = 1'b1;
    step(1);
    rd("post_rst_cycles", A_CYC, 32'h1);

    if (sb.size() != 0) check_val("sb_leftover", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data bus. It is the target end of the load/store interface that the core drives, serving an address window at IO_BASE.
- Owns the PortOut register, which software drives with sw.
- Synchronises PortIn into a readable register and provides a sticky input-change flag.
- Provides a free-running cycle counter.
- The top level uses Hit to steer ReadData between RAM and this block.

Parameters:
- IO_BASE, 32'hFFFF_0000, base byte address of the 16-byte register window; bits [3:0] must be 0.
- IN_WIDTH, 8, width of PortIn.
- SYNC_STAGES, 2, flop stages on PortIn; minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data (rt).
- MemWrite  input  1  store strobe.
- MemRead  input  1  load strobe.
- ReadData  output  32  load data, combinational.
- Hit  output  1  Address lies inside the window.
- PortIn  input  IN_WIDTH  asynchronous external inputs.
- PortOut  output  32  registered output port.
- InChanged  output  1  sticky change flag, for polling or a future interrupt.

Behaviour:
- Decode:
  - Hit = (Address[31:4] == IO_BASE[31:4]). Purely combinational.
  - Register select = Address[3:2]. Address[1:0] is ignored; only word access is supported.
- Register map (byte offsets):
  - 0x0 PORT_OUT, read/write.
  - 0x4 PORT_IN, read-only. Returns the synchronised value zero-extended to 32 bits.
  - 0x8 STATUS. Bit0 = changed flag, write-1-to-clear; bits [31:1] read as 0.
  - 0xC CYCLES, read/write. Free-running 32-bit counter; a write loads it.
- Read timing: single-cycle, zero latency, to suit the single-cycle core.
  - ReadData = selected register when MemRead && Hit; otherwise 32'h0.
  - No read side effects.
- Write timing: the register updates on the rising clk edge where MemWrite && Hit. Writes to PORT_IN are ignored.
- Simultaneous MemRead and MemWrite in one cycle: ReadData shows the pre-edge value; the write lands at the edge.
- Synchroniser and flag:
  - PortIn passes through SYNC_STAGES flops, giving sync_q, then one more flop, giving prev_q.
  - Changed flag sets on any cycle where sync_q != prev_q.
  - A W1C write with WriteData[0]=1 clears the flag. If a set event occurs in the same cycle, set wins and the flag stays 1.
  - Writing 0 to bit0 has no effect.
  - Input-to-PORT_IN latency is SYNC_STAGES cycles. The flag asserts SYNC_STAGES+1 edges after the input change.
- Counter:
  - Increments by 1 on every edge.
  - Wraps 32'hFFFF_FFFF to 0 without a flag.
  - A write to CYCLES loads WriteData at that edge; that edge does not increment. The next edge gives WriteData+1.
- Outputs: PortOut is the PORT_OUT register. InChanged is the flag.
- Reset (reset=0, asynchronous): PORT_OUT, all sync flops, prev_q, flag and counter are cleared to 0. As a result PortOut=0, InChanged=0, and PORT_IN reads 0.
  - A reset asserted mid-sequence discards any pending flag.
  - No edges are counted while reset is low.
  - Release is synchronous to clk through the normal flops.
- Accesses with Hit=0 have no effect on any state.

Decomposition:
- Package mmio_pkg holds the shared constants:
  - register offsets OFF_PORT_OUT=2'd0, OFF_PORT_IN=2'd1, OFF_STATUS=2'd2, OFF_CYCLES=2'd3;
  - STATUS_CHANGED_BIT=0;
  - default IO_BASE.
- Sub-module port_in_sync, parameterised by IN_WIDTH and SYNC_STAGES. It contains the flop chain, prev_q and the change pulse, and is reused for future input ports.

Test Plan:
- Reset, then sw of 32'hDEAD_BEEF to 0xFFFF_0000 → PortOut=32'hDEAD_BEEF after the edge. A lw of the same address returns 32'hDEAD_BEEF. Hit=1.
- PortIn changes 8'h00→8'hA5 → PORT_IN reads 32'h0000_00A5 after 2 edges. InChanged=1 after 3 edges. STATUS reads 32'h1.
- W1C on the flag: sw 32'h1 to 0xFFFF_0008 → InChanged=0. Repeat with a PortIn toggle timed so the set lands on the same edge → InChanged stays 1.
- Counter: sw 32'hFFFF_FFFE to 0xFFFF_000C → reads FFFF_FFFE, then FFFF_FFFF, then 0000_0000 on successive cycles.
- Out-of-window access at Address 32'h1001_0000 with MemWrite=1 and MemRead=1 → Hit=0, ReadData=0, PortOut unchanged.
- Assert reset mid-run with PortOut=32'h1234, the flag set and the counter nonzero → all read 0 immediately, without waiting for a clock edge.
